// File: rtl/adc_seq_pkg.sv
// Shared types and width helpers for the ADC scan sequencer.
//   state_t      : sequencer FSM states
//   ch_w()       : channel index width for a given channel count
//   cnt_w()      : width of a counter that must hold values 0..n
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CONVERT,
        OUTPUT
    } state_t;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_NCH         = 4;
    localparam int unsigned DEF_SETTLE_CYC  = 1000;
    localparam int unsigned DEF_AVG_LOG2    = 2;
    localparam int unsigned DEF_TIMEOUT_CYC = 66000;

    function automatic int unsigned ch_w(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Bus bundle between the scan sequencer and its surroundings.
//   slave  : the sequencer (takes control/ADC/ready, drives mux/enable/result)
//   master : the host side (drives control/ADC/ready, observes the rest)
interface adc_scan_sequencer_if
    import adc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned CH_W  = ch_w(NCH)
);
    logic             start;
    logic             continuous;
    logic             abort;
    logic [NCH-1:0]   ch_mask;
    logic [CH_W-1:0]  mux_sel;
    logic             adc_enable;
    logic             adc_valid;
    logic [WIDTH-1:0] adc_code;
    logic             res_valid;
    logic             res_ready;
    logic [CH_W-1:0]  res_channel;
    logic [WIDTH-1:0] res_code;
    logic             res_timeout;
    logic             busy;

    modport slave (
        input  start, continuous, abort, ch_mask, adc_valid, adc_code, res_ready,
        output mux_sel, adc_enable, res_valid, res_channel, res_code, res_timeout, busy
    );

    modport master (
        output start, continuous, abort, ch_mask, adc_valid, adc_code, res_ready,
        input  mux_sel, adc_enable, res_valid, res_channel, res_code, res_timeout, busy
    );
endinterface

// File: rtl/adc_next_channel.sv
// Combinational priority finder over a channel mask.
//   mask_i  : candidate channels
//   cur_i   : current channel index
//   first_i : 1 = lowest set bit of mask_i; 0 = lowest set bit strictly above cur_i
//   next_o  : found index (0 when none)
//   found_o : a qualifying bit exists
module adc_next_channel
    import adc_seq_pkg::*;
#(
    parameter int unsigned NCH  = DEF_NCH,
    parameter int unsigned CH_W = ch_w(NCH)
) (
    input  logic [NCH-1:0]  mask_i,
    input  logic [CH_W-1:0] cur_i,
    input  logic            first_i,
    output logic [CH_W-1:0] next_o,
    output logic            found_o
);
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (!found_o && mask_i[i] && (first_i || i > int'(cur_i))) begin
                next_o  = CH_W'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/adc_scan_sequencer.sv
// Multi-channel scan controller for the ramp-compare ADC. Settles the analog mux,
// collects 2^AVG_LOG2 conversions per channel, emits one averaged code per channel
// on a valid/ready port and walks the latched channel mask.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : control (start/continuous/abort/ch_mask), mux/ADC side
//             (mux_sel/adc_enable/adc_valid/adc_code), result port
//             (res_valid/res_ready/res_channel/res_code/res_timeout) and busy
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned NCH         = DEF_NCH,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset_n,
    adc_scan_sequencer_if.slave bus
);
    localparam int unsigned CH_W  = ch_w(NCH);
    localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
    localparam int unsigned TMO_W = cnt_w(TIMEOUT_CYC);
    localparam int unsigned SET_W = cnt_w(SETTLE_CYC);
    localparam int unsigned N_W   = AVG_LOG2 + 1;
    localparam logic [N_W-1:0] NSAMP = N_W'(2 ** AVG_LOG2);

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [SET_W-1:0] set_q, set_d;
    logic             tflag_q, tflag_d;

    logic [CH_W-1:0]  next_above, lowest;
    logic             found_above, found_lowest;
    logic [NCH-1:0]   lowest_mask;
    logic             sample;
    logic [WIDTH-1:0] sample_code;
    logic [N_W-1:0]   n_inc;

    // In IDLE the lowest-channel search runs on the live mask so start can latch it.
    assign lowest_mask = (state_q == IDLE) ? bus.ch_mask : mask_q;
    assign n_inc       = n_q + N_W'(1);

    adc_next_channel #(.NCH(NCH), .CH_W(CH_W)) u_next_above (
        .mask_i  (mask_q),
        .cur_i   (ch_q),
        .first_i (1'b0),
        .next_o  (next_above),
        .found_o (found_above)
    );

    adc_next_channel #(.NCH(NCH), .CH_W(CH_W)) u_lowest (
        .mask_i  (lowest_mask),
        .cur_i   ('0),
        .first_i (1'b1),
        .next_o  (lowest),
        .found_o (found_lowest)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        mask_d      = mask_q;
        acc_d       = acc_q;
        n_d         = n_q;
        tmo_d       = tmo_q;
        set_d       = set_q;
        tflag_d     = tflag_q;
        sample      = 1'b0;
        sample_code = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && found_lowest) begin
                    mask_d  = bus.ch_mask;
                    ch_d    = lowest;
                    set_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (set_q == SET_W'(SETTLE_CYC - 1)) begin
                    set_d   = '0;
                    tmo_d   = '0;
                    state_d = CONVERT;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            CONVERT: begin
                if (bus.adc_valid) begin
                    sample      = 1'b1;
                    sample_code = bus.adc_code;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    // Ramp never tripped the comparator: count it as full scale.
                    sample      = 1'b1;
                    sample_code = '1;
                    tflag_d     = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (sample) begin
                    acc_d = acc_q + ACC_W'(sample_code);
                    n_d   = n_inc;
                    tmo_d = '0;
                    if (n_inc == NSAMP) begin
                        state_d = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (bus.res_ready) begin
                    acc_d   = '0;
                    n_d     = '0;
                    tflag_d = 1'b0;
                    if (found_above) begin
                        ch_d    = next_above;
                        state_d = SETTLE;
                    end else if (bus.continuous) begin
                        ch_d    = lowest;
                        state_d = SETTLE;
                    end else begin
                        ch_d    = '0;
                        mask_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort) begin
            state_d = IDLE;
            ch_d    = '0;
            mask_d  = '0;
            acc_d   = '0;
            n_d     = '0;
            tmo_d   = '0;
            set_d   = '0;
            tflag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            tmo_q   <= '0;
            set_q   <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            tmo_q   <= tmo_d;
            set_q   <= set_d;
            tflag_q <= tflag_d;
        end
    end

    // Result fields are forced to 0 outside OUTPUT so a partial accumulation never leaks.
    assign bus.mux_sel     = ch_q;
    assign bus.adc_enable  = (state_q == CONVERT);
    assign bus.res_valid   = (state_q == OUTPUT);
    assign bus.res_channel = bus.res_valid ? ch_q : '0;
    assign bus.res_code    = bus.res_valid ? acc_q[ACC_W-1 -: WIDTH] : '0;
    assign bus.res_timeout = bus.res_valid & tflag_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned NCH         = 4;
    localparam int unsigned SETTLE_CYC  = 16;
    localparam int unsigned AVG_LOG2    = 2;
    localparam int unsigned TIMEOUT_CYC = 200;

    typedef struct {
        int ch;
        int code;
        int tmo;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    exp_t exp_q[$];

    // ADC model controls
    bit   silent = 1'b0;
    int   const_code = 0;
    int   code_q[$];
    int   gap = 0;

    adc_scan_sequencer_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    adc_scan_sequencer #(
        .WIDTH       (WIDTH),
        .NCH         (NCH),
        .SETTLE_CYC  (SETTLE_CYC),
        .AVG_LOG2    (AVG_LOG2),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int code, input int tmo);
        exp_t e;
        e.ch = ch;
        e.code = code;
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic start_scan(input logic [NCH-1:0] m, input string name);
        bus.ch_mask = m;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check(name, 32'(bus.busy), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i = 0;
        while (bus.busy && i < budget) begin
            cyc();
            i++;
        end
        check(name, 32'(bus.busy), 0);
    endtask

    // ADC model: one valid strobe every fifth enabled cycle.
    initial begin
        bus.adc_valid = 1'b0;
        bus.adc_code = '0;
        forever begin
            cyc();
            bus.adc_valid = 1'b0;
            if (bus.adc_enable && !silent) begin
                if (gap == 4) begin
                    gap = 0;
                    bus.adc_valid = 1'b1;
                    if (code_q.size() > 0) bus.adc_code = WIDTH'(code_q.pop_front());
                    else bus.adc_code = WIDTH'(const_code);
                end else begin
                    gap++;
                end
            end else begin
                gap = 0;
            end
        end
    end

    // Monitor: compare each accepted result against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got ch %0d code %0d expected none",
                         bus.res_channel, bus.res_code);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_channel", 32'(bus.res_channel), e.ch);
                check("res_code", 32'(bus.res_code), e.code);
                check("res_timeout", 32'(bus.res_timeout), e.tmo);
                pops++;
            end
        end
    end

    initial begin
        logic [7:0] hold_code;
        logic [1:0] hold_ch;
        bit         stable;
        int         i;
        int         p0;

        bus.start = 1'b0;
        bus.continuous = 1'b0;
        bus.abort = 1'b0;
        bus.ch_mask = '0;
        bus.res_ready = 1'b0;

        repeat (3) cyc();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_adc_enable", 32'(bus.adc_enable), 0);
        check("rst_mux_sel", 32'(bus.mux_sel), 0);
        check("rst_res_code", 32'(bus.res_code), 0);
        reset_n = 1'b1;
        cyc();

        // Start with an empty mask must be ignored
        bus.ch_mask = '0;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("empty_mask_ignored", 32'(bus.busy), 0);

        // 1: two channels, constant code
        bus.res_ready = 1'b1;
        const_code = 100;
        push(0, 100, 0);
        push(2, 100, 0);
        start_scan(4'b0101, "t1_start");
        wait_idle(600, "t1_idle");

        // 2: averaging 10,11,12,13 -> 46>>2 = 11
        code_q = '{10, 11, 12, 13};
        push(1, 11, 0);
        start_scan(4'b0010, "t2_start");
        wait_idle(400, "t2_idle");

        // 3: no strobes -> four timeouts of 255
        silent = 1'b1;
        push(0, 255, 1);
        start_scan(4'b0001, "t3_start");
        wait_idle(1500, "t3_idle");
        silent = 1'b0;

        // 4: back-pressure holds the result steady with the ADC off
        bus.res_ready = 1'b0;
        const_code = 77;
        start_scan(4'b0100, "t4_start");
        i = 0;
        while (!bus.res_valid && i < 300) begin
            cyc();
            i++;
        end
        check("t4_res_valid", 32'(bus.res_valid), 1);
        check("t4_code", 32'(bus.res_code), 77);
        hold_code = bus.res_code;
        hold_ch = bus.res_channel;
        stable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (!bus.res_valid || bus.res_code != hold_code || bus.res_channel != hold_ch ||
                bus.adc_enable)
                stable = 1'b0;
        end
        check("t4_stable", 32'(stable), 1);
        check("t4_adc_enable", 32'(bus.adc_enable), 0);
        push(2, 77, 0);
        bus.res_ready = 1'b1;
        wait_idle(50, "t4_idle");

        // 5: continuous single-channel rescans, then stop after the next result
        bus.continuous = 1'b1;
        const_code = 50;
        push(3, 50, 0);
        push(3, 50, 0);
        push(3, 50, 0);
        p0 = pops;
        start_scan(4'b1000, "t5_start");
        i = 0;
        while (pops < p0 + 2 && i < 600) begin
            cyc();
            i++;
        end
        check("t5_two_results", 32'(pops - p0), 2);
        bus.continuous = 1'b0;
        wait_idle(400, "t5_idle");
        check("t5_three_results", 32'(pops - p0), 3);

        // 6a: abort mid-CONVERT
        const_code = 30;
        start_scan(4'b0110, "t6_start");
        i = 0;
        while (!bus.adc_enable && i < 100) begin
            cyc();
            i++;
        end
        check("t6_in_convert", 32'(bus.adc_enable), 1);
        cyc();
        cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_adc_enable", 32'(bus.adc_enable), 0);
        check("abort_res_valid", 32'(bus.res_valid), 0);
        check("abort_mux_sel", 32'(bus.mux_sel), 0);

        // 6b: reset mid-SETTLE clears outputs immediately
        start_scan(4'b0110, "t6_restart");
        cyc();
        cyc();
        check("settle_mux_sel", 32'(bus.mux_sel), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_mux_sel", 32'(bus.mux_sel), 0);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // 6c: fresh scan starts at the lowest set channel
        const_code = 20;
        push(1, 20, 0);
        push(2, 20, 0);
        start_scan(4'b0110, "t6_new_start");
        wait_idle(600, "t6_idle");

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
